// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that owns the select of a shared 4:1 mux; grants are held
// for a burst, capped at MAX_HOLD cycles while another source is waiting.
module mux_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy
);

    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic [1:0]    last_q, last_d;
    logic [CW-1:0] hold_q, hold_d;

    logic [3:0]    owner_mask;
    logic [3:0]    others;
    logic          release_now;
    logic [2:0]    win;

    // Returns {found, index} of the first set bit searching from base+1, wrapping.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic [2:0] res;
        logic [1:0] idx;
        res = '0;
        for (int k = 4; k >= 1; k--) begin
            idx = base + 2'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        last_d      = last_q;
        hold_d      = hold_q;
        owner_mask  = 4'b0001 << sel_q;
        others      = req & ~owner_mask;
        release_now = 1'b0;
        win         = 3'b000;
        case (state_q)
            IDLE: begin
                win = rr_pick(req, last_q);
                if (win[2]) begin
                    state_d = GRANT;
                    sel_d   = win[1:0];
                    hold_d  = CW'(1);
                end
            end
            GRANT: begin
                release_now = !req[sel_q] || ((hold_q == HOLD_MAX) && (|others));
                if (release_now) begin
                    last_d = sel_q;
                    // Current owner is excluded so a preempted source cannot win back.
                    win = rr_pick(others, sel_q);
                    if (win[2]) begin
                        sel_d  = win[1:0];
                        hold_d = CW'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt  = (state_q == GRANT) ? (4'b0001 << sel_q) : 4'b0000;
        busy = (state_q == GRANT);
        sel  = sel_q;
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: a reference model queues expected outputs per cycle.
module tb_mux_rr_arbiter;

    localparam int MH = 8;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic [3:0] a_in;
    logic       mux_y;

    mux_rr_arbiter #(.MAX_HOLD(MH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .gnt  (gnt),
        .sel  (sel),
        .busy (busy)
    );

    assign mux_y = a_in[sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] g;
        logic [1:0] s;
        logic       b;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // reference model state
    bit       m_gr;
    int       m_owner;
    int       m_last;
    int       m_cnt;
    logic [3:0] prev_gnt;
    logic [1:0] prev_sel;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int first_from(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_gr = 0; m_owner = 0; m_last = 3; m_cnt = 0;
        prev_gnt = 4'b0000; prev_sel = 2'd0;
    endtask

    task automatic model_step(input logic [3:0] r);
        int w;
        logic [3:0] rest;
        if (!m_gr) begin
            w = first_from(r, m_last);
            if (w >= 0) begin
                m_gr = 1; m_owner = w; m_cnt = 1;
            end
        end else begin
            rest = r & ~(4'b0001 << m_owner);
            if (!r[m_owner] || (m_cnt == MH && rest != 4'b0000)) begin
                m_last = m_owner;
                w = first_from(rest, m_owner);
                if (w >= 0) begin
                    m_owner = w; m_cnt = 1;
                end else begin
                    m_gr = 0;
                end
            end else if (m_cnt < MH) begin
                m_cnt++;
            end
        end
    endtask

    task automatic step(input logic [3:0] r);
        exp_t e;
        req  = r;
        a_in = 4'($urandom);
        model_step(r);
        e.g = m_gr ? (4'b0001 << m_owner) : 4'b0000;
        e.s = 2'(m_owner);
        e.b = m_gr;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("gnt", 32'(gnt), 32'(e.g));
        chk("sel", 32'(sel), 32'(e.s));
        chk("busy", 32'(busy), 32'(e.b));
        chk("onehot", 32'($onehot0(gnt)), 32'd1);
        chk("busy_or", 32'(busy), 32'(|gnt));
        chk("mux", 32'(mux_y), 32'(a_in[e.s]));
        if (prev_gnt != 4'b0000 && gnt == prev_gnt)
            chk("sel_stable", 32'(sel), 32'(prev_sel));
        prev_gnt = gnt;
        prev_sel = sel;
    endtask

    // Asserts reset between edges and checks that outputs clear without a clock.
    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_sel"}, 32'(sel), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] r;
        a_in  = 4'b0000;
        req   = 4'b1111;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        #3;
        rst_n = 1'b1;

        // single requester holds indefinitely
        for (int i = 0; i < 20; i++) step(4'b0100);
        chk("single_gnt", 32'(gnt), 32'h4);
        chk("single_sel", 32'(sel), 32'd2);
        for (int i = 0; i < 3; i++) step(4'b0000);
        chk("drop_sel", 32'(sel), 32'd2);
        chk("drop_busy", 32'(busy), 32'd0);

        // fairness: 0,1,2,3,0 each for MH cycles
        pulse_reset("rst_b");
        for (int i = 0; i < 4 * MH + 2; i++) begin
            step(4'b1111);
            chk("rotate_owner", 32'(sel), 32'((i / MH) % 4));
            chk("rotate_busy", 32'(busy), 32'd1);
        end

        // voluntary drop: owner 1 with others waiting
        pulse_reset("rst_c");
        step(4'b0001);
        step(4'b0010);
        chk("own1", 32'(gnt), 32'h2);
        for (int i = 0; i < 3; i++) step(4'b1011);
        step(4'b1001);
        chk("vol_gnt", 32'(gnt), 32'h8);
        chk("vol_sel", 32'(sel), 32'd3);

        // wrap/priority: owner 3 released, then 0110 -> 1, then 0101 -> 2
        step(4'b0000);
        step(4'b0110);
        chk("wrap_sel1", 32'(sel), 32'd1);
        step(4'b0101);
        chk("wrap_sel2", 32'(sel), 32'd2);

        // mid-grant reset during owner-2 burst
        for (int i = 0; i < 3; i++) step(4'b0100);
        chk("pre_mid", 32'(gnt), 32'h4);
        pulse_reset("rst_mid");
        step(4'b1100);
        chk("post_rst_sel", 32'(sel), 32'd2);
        step(4'b0000);

        // random traffic with sticky requests
        r = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom);
            step(r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
